// File: rtl/ssm_y_dskip.sv
// SSM output skip path: y = sum_n(h*C) + D*x per (h,p) lane, FP16.
// D*x products wait in an order-preserving queue until the matching sum arrives.
module ssm_y_dskip #(
  parameter int DW       = 16,
  parameter int H_TILE   = 1,
  parameter int P_TILE   = 1,
  parameter int XQ_DEPTH = 8,
  parameter int MUL_LAT  = 2,
  parameter int ADD_LAT  = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              clr_i,
  input  logic                              x_valid_i,
  input  logic [H_TILE*P_TILE*DW-1:0]       x_i,
  input  logic [H_TILE*DW-1:0]              D_i,
  input  logic                              sum_valid_i,
  input  logic [H_TILE*P_TILE*DW-1:0]       sum_hp_i,
  output logic                              y_valid_o,
  output logic [H_TILE*P_TILE*DW-1:0]       y_o,
  output logic [$clog2(XQ_DEPTH):0]         xq_cnt_o,
  output logic                              err_ovf_o,
  output logic                              err_udf_o
);

  localparam int L  = H_TILE * P_TILE;
  localparam int W  = L * DW;
  localparam int AW = $clog2(XQ_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [15:0] rnd_pack(
    input logic s, input int e, input logic [9:0] m,
    input logic g, input logic st
  );
    logic [10:0] mr;
    int          ee;
    ee = e;
    mr = {1'b0, m} + {10'b0, g & (st | m[0])};
    if (mr[10]) ee = ee + 1;
    if (ee >= 31) return {s, 5'h1f, 10'h0};
    if (ee <= 0) return 16'h0000;
    return {s, ee[4:0], mr[9:0]};
  endfunction

  // Subnormal operands are treated as zero, matching the flush-to-zero results.
  function automatic logic [15:0] fmul(
    input logic [15:0] a, input logic [15:0] b
  );
    logic        s;
    logic [21:0] p;
    int          e;
    s = a[15] ^ b[15];
    if ((a[14:10] == 5'h1f && a[9:0] != 10'h0) ||
        (b[14:10] == 5'h1f && b[9:0] != 10'h0))
      return 16'h7E00;
    if ((a[14:10] == 5'h1f && b[14:10] == 5'h0) ||
        (b[14:10] == 5'h1f && a[14:10] == 5'h0))
      return 16'h7E00;
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f)
      return {s, 5'h1f, 10'h0};
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0)
      return {s, 15'h0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) e = e + 1;
    else p = p << 1;
    return rnd_pack(s, e, p[20:11], p[10], |p[9:0]);
  endfunction

  function automatic logic [15:0] fadd(
    input logic [15:0] a, input logic [15:0] b
  );
    logic [15:0] x, y;
    logic [25:0] am, bf, bm, r;
    logic [23:0] n;
    int          d, lead;
    if ((a[14:10] == 5'h1f && a[9:0] != 10'h0) ||
        (b[14:10] == 5'h1f && b[9:0] != 10'h0))
      return 16'h7E00;
    if (a[14:10] == 5'h1f && b[14:10] == 5'h1f)
      return (a[15] == b[15]) ? a : 16'h7E00;
    if (a[14:10] == 5'h1f) return a;
    if (b[14:10] == 5'h1f) return b;
    if (a[14:10] == 5'h0 && b[14:10] == 5'h0)
      return {a[15] & b[15], 15'h0};
    if (a[14:10] == 5'h0) return b;
    if (b[14:10] == 5'h0) return a;
    if (b[14:0] > a[14:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    d  = int'(x[14:10]) - int'(y[14:10]);
    am = {2'b01, x[9:0], 14'h0};
    bf = {2'b01, y[9:0], 14'h0};
    if (d > 25) begin
      bm = 26'h1;
    end else begin
      bm    = bf >> d;
      bm[0] = bm[0] | (|(bf & ((26'h1 << d) - 26'h1)));
    end
    r = (x[15] != y[15]) ? am - bm : am + bm;
    if (r == 26'h0) return 16'h0000;
    lead = 0;
    for (int i = 0; i < 26; i++)
      if (r[i]) lead = i;
    if (lead == 25) n = 24'(r >> 1) | 24'(r[0]);
    else n = 24'(r << (24 - lead));
    return rnd_pack(x[15], int'(x[14:10]) + lead - 24,
                    n[23:14], n[13], |n[12:0]);
  endfunction

  logic [W-1:0]       prod_c, dx_c, add_c;
  logic [W-1:0]       mul_d_q [MUL_LAT];
  logic [MUL_LAT-1:0] mul_v_q;
  logic [W-1:0]       add_d_q [ADD_LAT];
  logic [ADD_LAT-1:0] add_v_q;
  logic [W-1:0]       mem_q [XQ_DEPTH];
  logic [AW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d, udf_q, udf_d;
  logic               push_v, empty, full, do_pop, do_push;

  always_comb begin
    prod_c = '0;
    for (int hp = 0; hp < L; hp++)
      prod_c[DW*hp +: DW] = fmul(D_i[DW*(hp/P_TILE) +: DW],
                                 x_i[DW*hp +: DW]);
  end

  assign push_v  = mul_v_q[MUL_LAT-1];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(XQ_DEPTH));
  assign do_pop  = sum_valid_i & ~empty;
  assign do_push = push_v & (~full | do_pop);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (do_push) wp_d = wp_q + AW'(1);
      if (do_pop) rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      if (push_v & full & ~do_pop) ovf_d = 1'b1;
      if (sum_valid_i & empty) udf_d = 1'b1;
    end
  end

  // An empty queue contributes +0, so y passes the sum through unchanged.
  assign dx_c = do_pop ? mem_q[rp_q] : '0;

  always_comb begin
    add_c = '0;
    for (int hp = 0; hp < L; hp++)
      add_c[DW*hp +: DW] = fadd(sum_hp_i[DW*hp +: DW], dx_c[DW*hp +: DW]);
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wp_q] <= mul_d_q[MUL_LAT-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_v_q <= '0;
      add_v_q <= '0;
    end else if (clr_i) begin
      mul_v_q <= '0;
      add_v_q <= '0;
    end else begin
      mul_v_q[0] <= x_valid_i;
      for (int i = 1; i < MUL_LAT; i++) mul_v_q[i] <= mul_v_q[i-1];
      add_v_q[0] <= sum_valid_i;
      for (int i = 1; i < ADD_LAT; i++) add_v_q[i] <= add_v_q[i-1];
    end
  end

  // Data stages load only behind a valid, so the last stage holds y between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MUL_LAT; i++) mul_d_q[i] <= '0;
      for (int i = 0; i < ADD_LAT; i++) add_d_q[i] <= '0;
    end else begin
      if (x_valid_i) mul_d_q[0] <= prod_c;
      for (int i = 1; i < MUL_LAT; i++)
        if (mul_v_q[i-1]) mul_d_q[i] <= mul_d_q[i-1];
      if (sum_valid_i) add_d_q[0] <= add_c;
      for (int i = 1; i < ADD_LAT; i++)
        if (add_v_q[i-1]) add_d_q[i] <= add_d_q[i-1];
    end
  end

  assign y_valid_o = add_v_q[ADD_LAT-1];
  assign y_o       = add_d_q[ADD_LAT-1];
  assign xq_cnt_o  = cnt_q;
  assign err_ovf_o = ovf_q;
  assign err_udf_o = udf_q;

endmodule
